// File: rtl/vga_pkg.sv
// Shared VGA-path constants: default frame geometry, colour width,
// the transparent colour code and a small named palette.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_COLOR_W  = 3;

  // A layer showing this colour code lets lower-priority layers through.
  localparam int TRANSPARENT  = 0;

  localparam logic [DEF_COLOR_W-1:0] COLOR_BLACK   = 3'd0;
  localparam logic [DEF_COLOR_W-1:0] COLOR_BLUE    = 3'd1;
  localparam logic [DEF_COLOR_W-1:0] COLOR_GREEN   = 3'd2;
  localparam logic [DEF_COLOR_W-1:0] COLOR_CYAN    = 3'd3;
  localparam logic [DEF_COLOR_W-1:0] COLOR_RED     = 3'd4;
  localparam logic [DEF_COLOR_W-1:0] COLOR_MAGENTA = 3'd5;
  localparam logic [DEF_COLOR_W-1:0] COLOR_YELLOW  = 3'd6;
  localparam logic [DEF_COLOR_W-1:0] COLOR_WHITE   = 3'd7;

endpackage

// File: rtl/layer_priority_mux.sv
// Combinational priority select over NUM_LAYERS colour inputs.
// Layer 0 has the highest priority. A layer participates only when its
// enable bit is set and its colour is not TRANSPARENT; with no candidate
// the background colour is returned.
//   layer_color  in  NUM_LAYERS*COLOR_W  layer i at [i*COLOR_W +: COLOR_W]
//   layer_en     in  NUM_LAYERS          per-layer enable
//   color        out COLOR_W             winning colour
module layer_priority_mux
  import vga_pkg::*;
#(
  parameter int                 NUM_LAYERS = 4,
  parameter int                 COLOR_W    = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  output logic [COLOR_W-1:0]            color
);

  logic found;

  always_comb begin
    color = BG_COLOR;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
      if (!found && layer_en[i] &&
          layer_color[i*COLOR_W +: COLOR_W] != COLOR_W'(TRANSPARENT)) begin
        color = layer_color[i*COLOR_W +: COLOR_W];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/raster_compositor.sv
// Raster scan generator with an N-layer priority compositor.
// Walks the active frame in raster order, presents pixel_x/pixel_y to the
// layer generators, and pushes {color, addr, sof, eol} beats through a
// single registered output stage with a valid/ready handshake.
//   clk, rst     clock; synchronous active-high reset
//   enable       scanner may issue new pixels
//   layer_color  per-layer colours for the current pixel_x/pixel_y
//   layer_en     per-layer enables
//   pixel_x/y    current scan position (registered)
//   out_valid/out_ready  output handshake
//   out_color/out_addr/out_sof/out_eol  output beat
//   frame_count  completed frames, wraps at 2**16
module raster_compositor
  import vga_pkg::*;
#(
  parameter int                 H_ACTIVE   = DEF_H_ACTIVE,
  parameter int                 V_ACTIVE   = DEF_V_ACTIVE,
  parameter int                 NUM_LAYERS = 4,
  parameter int                 COLOR_W    = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] BG_COLOR   = '0,
  parameter int                 COORD_W    = 16,
  parameter int                 ADDR_W     = 19
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  output logic [COORD_W-1:0]            pixel_x,
  output logic [COORD_W-1:0]            pixel_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLOR_W-1:0]            out_color,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic [15:0]                   frame_count
);

  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [ADDR_W-1:0]  addr;
  logic [COLOR_W-1:0] mux_color;
  logic               issue;

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .COLOR_W    (COLOR_W),
    .BG_COLOR   (BG_COLOR)
  ) u_mux (
    .layer_color (layer_color),
    .layer_en    (layer_en),
    .color       (mux_color)
  );

  // A new beat may enter the output stage when it is empty or being drained
  // this very cycle, which gives back-to-back beats with out_ready high.
  assign issue = enable && (!out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x     <= '0;
      pixel_y     <= '0;
      addr        <= '0;
      out_valid   <= 1'b0;
      out_color   <= '0;
      out_addr    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      frame_count <= '0;
    end else begin
      if (out_valid && out_ready && out_addr == ADDR_LAST)
        frame_count <= frame_count + 16'd1;

      if (issue) begin
        out_valid <= 1'b1;
        out_color <= mux_color;
        out_addr  <= addr;
        out_sof   <= (addr == '0);
        out_eol   <= (pixel_x == X_LAST);

        // Linear address tracks the scan position incrementally and wraps
        // with it on the last pixel of the frame.
        if (pixel_x == X_LAST) begin
          pixel_x <= '0;
          if (pixel_y == Y_LAST) begin
            pixel_y <= '0;
            addr    <= '0;
          end else begin
            pixel_y <= pixel_y + COORD_W'(1);
            addr    <= addr + ADDR_W'(1);
          end
        end else begin
          pixel_x <= pixel_x + COORD_W'(1);
          addr    <= addr + ADDR_W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_raster_compositor.sv
module tb_raster_compositor;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int NL = 4;
  localparam int CW = 3;
  localparam logic [CW-1:0] BG = 3'd6;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [NL*CW-1:0]  layer_color;
  logic [NL-1:0]     layer_en;
  logic [15:0]       pixel_x, pixel_y;
  logic              out_valid, out_ready;
  logic [CW-1:0]     out_color;
  logic [18:0]       out_addr;
  logic              out_sof, out_eol;
  logic [15:0]       frame_count;

  logic              pat_mode;
  logic [NL*CW-1:0]  fixed_color;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  raster_compositor #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .NUM_LAYERS (NL),
    .COLOR_W    (CW),
    .BG_COLOR   (BG),
    .COORD_W    (16),
    .ADDR_W     (19)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .layer_color (layer_color),
    .layer_en    (layer_en),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_color   (out_color),
    .out_addr    (out_addr),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .frame_count (frame_count)
  );

  // Test pattern per layer as a function of position.
  function automatic logic [CW-1:0] lay(input int i, input int x, input int y);
    case (i)
      0:       return (x == y) ? 3'd7 : 3'd0;
      1:       return (x % 2 == 1) ? 3'd5 : 3'd0;
      2:       return ((y / 2) % 2 == 1) ? 3'd2 : 3'd0;
      default: return (x >= 4) ? 3'd1 : 3'd0;
    endcase
  endfunction

  function automatic logic [CW-1:0] col_model(input int a, input logic [NL-1:0] en);
    int x, y;
    x = a % H;
    y = a / H;
    if (en[0] && lay(0, x, y) != 0) return lay(0, x, y);
    else if (en[1] && lay(1, x, y) != 0) return lay(1, x, y);
    else if (en[2] && lay(2, x, y) != 0) return lay(2, x, y);
    else if (en[3] && lay(3, x, y) != 0) return lay(3, x, y);
    else return BG;
  endfunction

  always_comb begin
    layer_color = fixed_color;
    if (pat_mode)
      layer_color = {lay(3, int'(pixel_x), int'(pixel_y)), lay(2, int'(pixel_x), int'(pixel_y)),
                     lay(1, int'(pixel_x), int'(pixel_y)), lay(0, int'(pixel_x), int'(pixel_y))};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a, last, acc, expa;
    logic v, r;
    logic [18:0] ca;
    logic [CW-1:0] cc;

    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    layer_en = '1; pat_mode = 1'b1; fixed_color = '0;
    repeat (3) step();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_px", 32'(pixel_x), 0);
    check("rst_py", 32'(pixel_y), 0);
    check("rst_addr", 32'(out_addr), 0);
    check("rst_fc", 32'(frame_count), 0);

    // Full frame at 1 pixel/clk, plus first beat of the next frame.
    rst = 1'b0; enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      step();
      a = k % 32;
      check("frm_valid", 32'(out_valid), 1);
      check("frm_addr", 32'(out_addr), 32'(a));
      check("frm_sof", 32'(out_sof), 32'(a == 0));
      check("frm_eol", 32'(out_eol), 32'(a % H == H - 1));
      check("frm_color", 32'(out_color), 32'(col_model(a, 4'hF)));
      if (k == 31) check("frm_fc0", 32'(frame_count), 0);
      if (k == 32) check("frm_fc1", 32'(frame_count), 1);
    end

    // Priority with fixed colours {L3,L2,L1,L0}.
    pat_mode = 1'b0;
    fixed_color = {3'd0, 3'd3, 3'd5, 3'd0};
    step(); check("pri_1111", 32'(out_color), 5);
    layer_en = 4'b1101;
    step(); check("pri_1101", 32'(out_color), 3);
    layer_en = 4'b1111; fixed_color = '0;
    step(); check("pri_bg", 32'(out_color), 32'(BG));
    layer_en = 4'b1110; fixed_color = {3'd0, 3'd0, 3'd5, 3'd7};
    step(); check("pri_mask0", 32'(out_color), 5);
    check("pri_addr", 32'(out_addr), 4);
    pat_mode = 1'b1; layer_en = 4'b1111;

    // Stall at addr 10.
    for (int i = 0; i < 20 && out_addr != 19'd10; i++) step();
    check("stl_reach", 32'(out_addr), 10);
    out_ready = 1'b0;
    repeat (5) begin
      step();
      check("stl_valid", 32'(out_valid), 1);
      check("stl_addr", 32'(out_addr), 10);
      check("stl_color", 32'(out_color), 32'(col_model(10, 4'hF)));
      check("stl_px", 32'(pixel_x), 3);
      check("stl_py", 32'(pixel_y), 1);
    end
    out_ready = 1'b1;
    step(); check("stl_next", 32'(out_addr), 11);

    // enable low with the x=4 beat pending.
    for (int i = 0; i < 20 && out_addr % H != 4; i++) step();
    check("en_reach", 32'(out_addr % H), 4);
    last = int'(out_addr);
    enable = 1'b0;
    repeat (3) begin
      step();
      check("en_valid", 32'(out_valid), 0);
      check("en_px", 32'(pixel_x), 5);
    end
    enable = 1'b1;
    step();
    check("en_resume_valid", 32'(out_valid), 1);
    check("en_resume_addr", 32'(out_addr), 32'(last + 1));

    // Reset during a stall at scan position (3,2).
    for (int i = 0; i < 40 && !(pixel_x == 3 && pixel_y == 2); i++) step();
    check("rs_reach", 32'(pixel_y * H + pixel_x), 19);
    out_ready = 1'b0;
    step(); check("rs_hold", 32'(out_addr), 18);
    rst = 1'b1;
    step();
    check("rs_valid", 32'(out_valid), 0);
    check("rs_px", 32'(pixel_x), 0);
    check("rs_py", 32'(pixel_y), 0);
    check("rs_fc", 32'(frame_count), 0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    check("rs_addr", 32'(out_addr), 0);
    check("rs_sof", 32'(out_sof), 1);
    check("rs_fc_after", 32'(frame_count), 0);

    // Random handshake/enable over three frames.
    acc = 0; expa = 0;
    for (int cyc = 0; cyc < 3000 && acc < 96; cyc++) begin
      enable = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      v = out_valid; r = out_ready; ca = out_addr; cc = out_color;
      step();
      if (v && r) begin
        check("rnd_addr", 32'(ca), 32'(expa));
        check("rnd_color", 32'(cc), 32'(col_model(expa, 4'hF)));
        expa = (expa + 1) % 32;
        acc++;
      end else if (v) begin
        check("rnd_hold_valid", 32'(out_valid), 1);
        check("rnd_hold_addr", 32'(out_addr), 32'(ca));
      end
    end
    check("rnd_beats", 32'(acc), 96);
    check("rnd_fc", 32'(frame_count), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
